// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception sequencer.
package exc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_READ,
    ST_LOAD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OPC  = 2'b01,
    CAUSE_OVF  = 2'b10,
    CAUSE_DIV0 = 2'b11
  } cause_e;

  localparam int   VEC_BASE_DEF = 253;
  localparam logic EX_SEL_PC    = 1'b0;
  localparam logic EX_SEL_MEM   = 1'b1;

  // Vector-table byte for a cause: base + (cause - 1).
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] c);
    return base + {30'd0, c} - 32'd1;
  endfunction

endpackage

// File: rtl/exc_if.sv
// Datapath <-> exception sequencer signal bundle.
interface exc_if;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] epc_out;
  logic        epc_wr;
  logic        ex_sel;
  logic        pc_wr;
  logic        busy;
  logic [1:0]  cause;

  modport master (
    input  exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    output mem_addr, mem_rd, epc_out, epc_wr, ex_sel, pc_wr, busy, cause
  );

  modport slave (
    output exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    input  mem_addr, mem_rd, epc_out, epc_wr, ex_sel, pc_wr, busy, cause
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: opcode > overflow > div0.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic   i_opc,
  input  logic   i_ovf,
  input  logic   i_div0,
  output cause_e o_cause,
  output logic   o_vld
);

  always_comb begin
    o_cause = CAUSE_NONE;
    if (i_opc)       o_cause = CAUSE_OPC;
    else if (i_ovf)  o_cause = CAUSE_OVF;
    else if (i_div0) o_cause = CAUSE_DIV0;
  end

  assign o_vld = i_opc | i_ovf | i_div0;

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: save EPC, fetch handler byte from vector table, load PC.
// Optional EXC_CAUSE_REG_EN exposes the latched cause; otherwise cause reads 00.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int VEC_BASE = VEC_BASE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  exc_if.master bus
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  cause_e      w_det_cause;
  logic        w_det_vld;

  state_e      r_state, w_nxt;
  logic [2:0]  r_cnt, w_cnt;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [31:0] r_epc_out, w_epc_out;
  logic        r_mem_rd, w_mem_rd;
  logic        r_epc_wr, w_epc_wr;
  logic        r_ex_sel, w_ex_sel;
  logic        r_pc_wr, w_pc_wr;
  logic        r_busy, w_busy;
  cause_e      r_cause, w_cause;

  exc_prio_enc u_prio (
    .i_opc   (bus.exc_opcode),
    .i_ovf   (bus.exc_ovf),
    .i_div0  (bus.exc_div0),
    .o_cause (w_det_cause),
    .o_vld   (w_det_vld)
  );

  // Outputs are computed for the state being entered, so every output
  // register lines up with the state register.
  always_comb begin
    w_nxt      = r_state;
    w_cnt      = r_cnt;
    w_mem_addr = r_mem_addr;
    w_epc_out  = r_epc_out;
    w_cause    = r_cause;
    w_mem_rd   = 1'b0;
    w_epc_wr   = 1'b0;
    w_ex_sel   = EX_SEL_PC;
    w_pc_wr    = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_det_vld) begin
          w_nxt     = ST_SAVE;
          w_cause   = w_det_cause;
          w_epc_wr  = 1'b1;
          w_epc_out = bus.pc_in - 32'd4;
          w_busy    = 1'b1;
        end
      end
      ST_SAVE: begin
        w_nxt      = ST_READ;
        w_cnt      = 3'd0;
        w_mem_rd   = 1'b1;
        w_mem_addr = vec_addr(32'(VEC_BASE), r_cause);
      end
      ST_READ: begin
        if (r_cnt == LAT_M1) begin
          w_nxt    = ST_LOAD;
          w_ex_sel = EX_SEL_MEM;
          w_pc_wr  = 1'b1;
        end else begin
          w_cnt    = r_cnt + 3'd1;
          w_mem_rd = 1'b1;
        end
      end
      ST_LOAD: begin
        w_nxt      = ST_DONE;
        w_mem_addr = 32'd0;
      end
      ST_DONE: begin
        w_nxt  = ST_IDLE;
        w_busy = 1'b0;
      end
      default: begin
        w_nxt  = ST_IDLE;
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_mem_addr <= 32'd0;
      r_epc_out  <= 32'd0;
      r_mem_rd   <= 1'b0;
      r_epc_wr   <= 1'b0;
      r_ex_sel   <= EX_SEL_PC;
      r_pc_wr    <= 1'b0;
      r_busy     <= 1'b0;
      r_cause    <= CAUSE_NONE;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt;
      r_mem_addr <= w_mem_addr;
      r_epc_out  <= w_epc_out;
      r_mem_rd   <= w_mem_rd;
      r_epc_wr   <= w_epc_wr;
      r_ex_sel   <= w_ex_sel;
      r_pc_wr    <= w_pc_wr;
      r_busy     <= w_busy;
      r_cause    <= w_cause;
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.epc_out  = r_epc_out;
  assign bus.epc_wr   = r_epc_wr;
  assign bus.ex_sel   = r_ex_sel;
  assign bus.pc_wr    = r_pc_wr;
  assign bus.busy     = r_busy;
`ifdef EXC_CAUSE_REG_EN
  assign bus.cause    = r_cause;
`else
  assign bus.cause    = CAUSE_NONE;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Two sequencers (MEM_LAT 1 and 3) on shared stimulus, scoreboarded against a spec-level model.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  typedef struct {
    logic [31:0] epc;
    logic [31:0] addr;
    logic [1:0]  cause;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        t_opc = 1'b0, t_ovf = 1'b0, t_div0 = 1'b0;
  logic [31:0] t_pc = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  int nf[2];
  item_t q0[$];
  item_t q1[$];

  logic       act[2];
  int         cyc[2];
  item_t      cur[2];
  logic [1:0] last_cause[2];

  always #5 clk = ~clk;

  exc_if if0 ();
  exc_if if1 ();

  assign if0.exc_opcode = t_opc;
  assign if0.exc_ovf    = t_ovf;
  assign if0.exc_div0   = t_div0;
  assign if0.pc_in      = t_pc;
  assign if0.mem_data   = {24'd0, 8'hA8};
  assign if1.exc_opcode = t_opc;
  assign if1.exc_ovf    = t_ovf;
  assign if1.exc_div0   = t_div0;
  assign if1.pc_in      = t_pc;
  assign if1.mem_data   = {24'd0, 8'hC4};

  exc_ctrl #(.MEM_LAT(1), .VEC_BASE(253)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  exc_ctrl #(.MEM_LAT(3), .VEC_BASE(253)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] vis_cause(input logic [1:0] c);
`ifdef EXC_CAUSE_REG_EN
    return c;
`else
    return (c == 2'b00) ? c : 2'b00;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Reference: an accepted exception occupies the sequencer for MEM_LAT+3
  // busy cycles; the first edge that can accept a new one is detect+MEM_LAT+4.
  task automatic model(input logic o, input logic v, input logic d, input logic [31:0] pc);
    logic [1:0] c;
    item_t it;
    c = o ? 2'd1 : v ? 2'd2 : d ? 2'd3 : 2'd0;
    if (c == 2'd0) return;
    it.epc = pc - 32'd4;
    it.addr = 32'd253 + 32'(c) - 32'd1;
    it.cause = c;
    for (int k = 0; k < 2; k++) begin
      if (e >= nf[k]) begin
        if (k == 0) q0.push_back(it); else q1.push_back(it);
        nf[k] = e + lat(k) + 4;
      end
    end
  endtask

  task automatic step(input logic o, input logic v, input logic d, input logic [31:0] pc);
    @(posedge clk); #2;
    e++;
    t_opc = o; t_ovf = v; t_div0 = d; t_pc = pc;
    model(o, v, d, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  // Cycle n after detect: 1 SAVE, 2..L+1 READ, L+2 LOAD, L+3 DONE.
  task automatic mon(input int k, input logic [31:0] maddr, input logic [31:0] epc,
                     input logic rd, input logic ewr, input logic xs, input logic pwr,
                     input logic bsy, input logic [1:0] cs);
    int L;
    logic empty;
    item_t it;
    string p;
    L = lat(k);
    p = (k == 0) ? "lat1" : "lat3";
    if (!reset_n) begin
      chk({p, " reset outputs"}, {maddr[15:0], epc[15:0]} | {27'd0, rd, ewr, xs, pwr, bsy} | {30'd0, cs}, 32'd0);
      act[k] = 1'b0;
      last_cause[k] = 2'd0;
      return;
    end
    if (!act[k]) begin
      if (!ewr) begin
        chk({p, " idle ctl {busy,rd,pcwr,exsel}"}, {28'd0, bsy, rd, pwr, xs}, 32'd0);
        chk({p, " idle mem_addr"}, maddr, 32'd0);
        chk({p, " idle cause"}, {30'd0, cs}, {30'd0, vis_cause(last_cause[k])});
        return;
      end
      empty = 1'b0;
      if (k == 0) begin if (q0.size() > 0) it = q0.pop_front(); else empty = 1'b1; end
      else        begin if (q1.size() > 0) it = q1.pop_front(); else empty = 1'b1; end
      if (empty) begin
        chk({p, " unexpected epc_wr"}, 32'd1, 32'd0);
        return;
      end
      cur[k] = it;
      act[k] = 1'b1;
      cyc[k] = 1;
      last_cause[k] = it.cause;
    end
    chk({p, " ctl {busy,rd,epcwr,pcwr,exsel}"}, {27'd0, bsy, rd, ewr, pwr, xs},
        {27'd0, cyc[k] <= L + 3, cyc[k] >= 2 && cyc[k] <= L + 1, cyc[k] == 1,
         cyc[k] == L + 2, cyc[k] == L + 2});
    chk({p, " mem_addr"}, maddr, (cyc[k] >= 2 && cyc[k] <= L + 2) ? cur[k].addr : 32'd0);
    chk({p, " epc_out"}, epc, cur[k].epc);
    chk({p, " cause"}, {30'd0, cs}, {30'd0, vis_cause(cur[k].cause)});
    cyc[k]++;
    if (cyc[k] > L + 3) act[k] = 1'b0;
  endtask

  always @(negedge clk) mon(0, if0.mem_addr, if0.epc_out, if0.mem_rd, if0.epc_wr, if0.ex_sel,
                            if0.pc_wr, if0.busy, if0.cause);
  always @(negedge clk) mon(1, if1.mem_addr, if1.epc_out, if1.mem_rd, if1.epc_wr, if1.ex_sel,
                            if1.pc_wr, if1.busy, if1.cause);

  initial begin
    act = '{1'b0, 1'b0};
    cyc = '{0, 0};
    nf = '{0, 0};
    last_cause = '{2'd0, 2'd0};
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    step(1'b0, 1'b1, 1'b0, 32'h0000_0104); idle(9);   // overflow, EPC 0x100, addr 254
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040); idle(9);   // opcode beats div0
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000); idle(9);   // div0, EPC wraps to FFFFFFFC
    step(1'b0, 1'b1, 1'b0, 32'h0000_2000); idle(2);   // re-pulse while busy is dropped
    step(1'b0, 1'b1, 1'b0, 32'h0000_3000); idle(9);

    // Abort mid-READ in both instances.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0500); idle(1);
    @(posedge clk); #2;
    e++;
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("lat1 async reset", {if0.mem_addr[15:0], if0.epc_out[15:0]} |
        {27'd0, if0.mem_rd, if0.epc_wr, if0.ex_sel, if0.pc_wr, if0.busy}, 32'd0);
    chk("lat3 async reset", {if1.mem_addr[15:0], if1.epc_out[15:0]} |
        {27'd0, if1.mem_rd, if1.epc_wr, if1.ex_sel, if1.pc_wr, if1.busy}, 32'd0);
    @(posedge clk); #2;
    e++;
    reset_n = 1'b1;
    nf = '{0, 0};
    idle(10);

    for (int i = 0; i < 500; i++) begin
      logic [2:0] x;
      logic [31:0] pc;
      x = ($urandom_range(3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      pc = ($urandom_range(7) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      step(x[2], x[1], x[0], pc);
    end
    idle(15);
    chk("lat1 leftover expected", 32'(q0.size()), 32'd0);
    chk("lat3 leftover expected", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception sequencer for the multicycle MIPS datapath. It is the producing end of the PC-vs-memory selection path: it detects an exception, saves EPC, and fetches the handler address byte from the memory vector table. It then drives the EX select (0 = PCSource_out, 1 = Mem_out) and the PC write, so PC is loaded from memory. While it runs, it stalls the main control unit.

Parameters:
MEM_LAT, 1, memory read latency in cycles (1..7) between mem_rd assert and valid mem_data
VEC_BASE, 253, memory address of the first vector-table byte

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
exc_opcode  in  1  invalid-opcode pulse from control unit
exc_ovf  in  1  ALU overflow pulse
exc_div0  in  1  divide-by-zero pulse from div unit
pc_in  in  32  current PC (already PC+4)
mem_data  in  32  memory read data; bits [7:0] hold the handler address
mem_addr  out  32  vector-table address
mem_rd  out  1  memory read strobe
epc_out  out  32  value for the EPC register
epc_wr  out  1  EPC write enable
ex_sel  out  1  EX mux select: 0 = PCSource_out, 1 = Mem_out
pc_wr  out  1  PC write enable (exception path)
busy  out  1  stall to main control; high from detect until return to IDLE
cause  out  2  00 none, 01 opcode, 10 overflow, 11 div0

Behaviour:
- Reset (async, reset_n=0) forces:
  - state IDLE
  - outputs mem_addr, epc_out and cause all 0
  - mem_rd, epc_wr, ex_sel, pc_wr and busy all 0
  - wait counter 0
- FSM states: IDLE, SAVE, READ, LOAD, DONE.
- IDLE:
  - Any exc_* high at a clk edge latches the cause, then goes to SAVE.
  - Priority when several are high: opcode > overflow > div0. Lower-priority pulses are dropped.
- SAVE (1 cycle):
  - epc_wr=1, epc_out = pc_in - 4 (32-bit modular; pc_in=0 gives 0xFFFFFFFC).
  - busy=1.
- READ:
  - mem_rd=1; mem_addr = VEC_BASE + (cause-1), i.e. 253/254/255.
  - Stays MEM_LAT cycles, counted by a 3-bit counter, then goes to LOAD.
- LOAD (1 cycle):
  - ex_sel=1 and pc_wr=1.
  - The datapath captures Mem_out, which is mem_data zero-extended from [7:0]. The block itself does not drive PC data.
- DONE (1 cycle):
  - busy=1, then back to IDLE.
  - ex_sel returns to 0 on the same edge as leaving LOAD.
- busy is high in all states except IDLE. mem_addr holds its value through LOAD and clears in DONE.
- Total latency from the detect edge to the pc_wr cycle is 2+MEM_LAT cycles.
- Any exc_* pulse while busy is ignored. There is no queueing and no nesting.
- cause is held from detection until the next exception. It is not cleared on return.
- Reset asserted mid-sequence aborts immediately. No partial EPC or PC write is issued after reset is released.
- All outputs are registered, with no combinational path from exc_* to outputs.

Optional Feature:
EXC_CAUSE_REG_EN:
- Defined: cause is a registered output as above, and the Cause value is latched alongside EPC.
- Undefined: the cause output is tied to 2'b00. The internal cause still selects the vector address, so behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SAVE, READ, LOAD, DONE)
  - cause encodings (CAUSE_NONE/OPC/OVF/DIV0)
  - VEC_BASE default
  - EX_SEL_PC=0 and EX_SEL_MEM=1
- One natural sub-module: exc_prio_enc, a combinational priority encoder from the three exc_* inputs to the 2-bit cause plus a valid flag.
- The FSM and counter stay in exc_ctrl.

Test Plan:
1. Reset mid-READ (reset_n low for 1 cycle) -> all outputs 0 immediately, state IDLE, no pc_wr ever follows.
2. exc_ovf pulse, pc_in=0x00000104, MEM_LAT=1, mem_data=0x000000A8 -> expected:
   - epc_wr with epc_out=0x00000100 one cycle after detect
   - mem_addr=254 with mem_rd
   - pc_wr and ex_sel=1 at detect+3
   - cause=10
3. exc_opcode and exc_div0 in the same cycle, pc_in=0x40 -> cause=01, mem_addr=253, epc_out=0x3C, div0 dropped.
4. exc_div0 with MEM_LAT=3 -> mem_rd held exactly 3 cycles at mem_addr=255; pc_wr at detect+5; busy high for 6 cycles.
5. exc_ovf re-pulsed during READ -> ignored: a single epc_wr and a single pc_wr; cause unchanged.
6. Build without EXC_CAUSE_REG_EN, exc_div0 -> cause stays 00 while mem_addr=255 and timing match scenario 4.
